wb_step_master: RTL and testbench

//  Wishbone initiator that drives the design multiplexer's control interface to single-step a selected design.
//  On start it takes override of the selected design, then repeats a loop: toggle the clock high, toggle it low, read the IO outputs.

---
 rtl/wb_step_master.sv | 174 +++++++++++++++++
 tb/tb_wb_step_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_step_master.sv
// rtl/wb_step_master.sv - Wishbone initiator that single-steps a design through the multiplexer control interface
module wb_step_master #(
    parameter logic [31:0] CTRL_ADDR       = 32'h3080_0000,
    parameter logic [31:0] IO_ADDR         = 32'h3040_0000,
    parameter int          ACK_TIMEOUT     = 16,
    parameter bit          RELEASE_ON_DONE = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [3:0]  design_sel_i,
    input  logic        hold_rst_i,
    input  logic [15:0] step_count_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [27:0] sample_o,
    output logic        sample_vld_o,
    output logic [15:0] steps_done_o
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CLK_HI, S_CLK_LO, S_SAMPLE, S_RELEASE, S_GAP, S_DONE
    } state_t;

    state_t        state, state_nxt, ret_state, follow_state, fin_state;
    logic [3:0]    sel_q;
    logic          rst_q;
    logic [15:0]   count_q;
    logic [15:0]   steps_done_q;
    logic [27:0]   sample_q;
    logic          sample_vld_q;
    logic          err_q;
    logic          abort_q;
    logic [TW-1:0] to_cnt;
    logic          bus_state;
    logic          more_steps;
    logic          abort_any;
    logic          timeout_hit;
    logic          unused_dat;

    assign unused_dat  = ^wbm_dat_i[31:28];
    assign bus_state   = (state == S_SETUP) || (state == S_CLK_HI) || (state == S_CLK_LO) ||
                         (state == S_SAMPLE) || (state == S_RELEASE);
    assign fin_state   = RELEASE_ON_DONE ? S_RELEASE : S_DONE;
    assign more_steps  = ({1'b0, steps_done_q} + 17'd1) < {1'b0, count_q};
    assign abort_any   = abort_q || abort_i;
    assign timeout_hit = bus_state && !wbm_ack_i && (to_cnt == TW'(ACK_TIMEOUT - 1));

    // Where the sequence continues once the current bus cycle has been acknowledged
    always_comb begin
        follow_state = S_DONE;
        case (state)
            S_SETUP:  follow_state = (count_q == 16'd0) ? fin_state : S_CLK_HI;
            S_CLK_HI: follow_state = S_CLK_LO;
            S_CLK_LO: follow_state = S_SAMPLE;
            S_SAMPLE: follow_state = more_steps ? S_CLK_HI : fin_state;
            default:  follow_state = S_DONE;
        endcase
    end

    // Next-state logic; abort only redirects at the end of a GAP so bus cycles always complete
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_SETUP;
            S_SETUP, S_CLK_HI, S_CLK_LO, S_SAMPLE, S_RELEASE: begin
                if (wbm_ack_i)        state_nxt = S_GAP;
                else if (timeout_hit) state_nxt = S_DONE;
            end
            S_GAP: begin
                if (!wbm_ack_i) begin
                    if (abort_any && ((ret_state == S_CLK_HI) || (ret_state == S_CLK_LO) ||
                                      (ret_state == S_SAMPLE)))
                        state_nxt = fin_state;
                    else
                        state_nxt = ret_state;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus drive derived from the current state; idle/gap states present an all-zero bus
    always_comb begin
        wbm_cyc_o = bus_state;
        wbm_stb_o = bus_state;
        wbm_we_o  = bus_state && (state != S_SAMPLE);
        wbm_adr_o = 32'h0;
        wbm_dat_o = 32'h0;
        if (state == S_SAMPLE)  wbm_adr_o = IO_ADDR;
        else if (bus_state)     wbm_adr_o = CTRL_ADDR;
        if ((state == S_SETUP) || (state == S_CLK_LO))
            wbm_dat_o = {24'b0, sel_q, 1'b0, 1'b1, rst_q, 1'b1};
        else if (state == S_CLK_HI)
            wbm_dat_o = {24'b0, sel_q, 1'b1, 1'b1, rst_q, 1'b1};
    end

    // State, return-state and acknowledge-timeout counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            to_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (bus_state && wbm_ack_i) ret_state <= follow_state;
            if (bus_state && !wbm_ack_i && !timeout_hit) to_cnt <= to_cnt + TW'(1);
            else                                         to_cnt <= '0;
        end
    end

    // Sequence parameters latched at start, plus pending-abort and sticky error flags
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sel_q   <= 4'h0;
            rst_q   <= 1'b0;
            count_q <= 16'h0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                abort_q <= start_i && abort_i;
                if (start_i) begin
                    sel_q   <= design_sel_i;
                    rst_q   <= hold_rst_i;
                    count_q <= step_count_i;
                    err_q   <= 1'b0;
                end
            end else if ((state == S_DONE) || ((state == S_GAP) && !wbm_ack_i)) begin
                abort_q <= 1'b0;
            end else if (abort_i) begin
                abort_q <= 1'b1;
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    // IO readback capture and step counting on each acknowledged sample read
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sample_q     <= 28'h0;
            sample_vld_q <= 1'b0;
            steps_done_q <= 16'h0;
        end else begin
            sample_vld_q <= 1'b0;
            if ((state == S_IDLE) && start_i) steps_done_q <= 16'h0;
            if ((state == S_SAMPLE) && wbm_ack_i) begin
                sample_q     <= wbm_dat_i[27:0];
                sample_vld_q <= 1'b1;
                steps_done_q <= steps_done_q + 16'd1;
            end
        end
    end

    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_DONE);
    assign err_o        = err_q;
    assign sample_o     = sample_q;
    assign sample_vld_o = sample_vld_q;
    assign steps_done_o = steps_done_q;

endmodule

// File: tb/tb_wb_step_master.sv
// tb/tb_wb_step_master.sv - directed self-checking bench for wb_step_master
module tb_wb_step_master;

    localparam logic [31:0] CTRL = 32'h3080_0000;
    localparam logic [31:0] IO   = 32'h3040_0000;
    localparam logic [31:0] BASE = 32'hF123_4560;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, hold_rst;
    logic [3:0]  sel;
    logic [15:0] count;
    logic [31:0] adr, dat, dat_i;
    logic        we, cyc, stb, ack;
    logic        busy, done, err, sample_vld;
    logic [27:0] sample;
    logic [15:0] steps_done;

    int n_cmp = 0;
    int n_bad = 0;

    int delay = 2, linger = 0, age = 0, linger_left = 0, rd_idx = 0;
    int viol = 0, max_age = 0, vld_cnt = 0, done_cnt = 0, lo_seen = 0;
    bit noack_hi = 1'b0;
    logic [64:0] log_q[$];
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    wb_step_master dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .design_sel_i(sel), .hold_rst_i(hold_rst), .step_count_i(count),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack), .busy_o(busy), .done_o(done), .err_o(err),
        .sample_o(sample), .sample_vld_o(sample_vld), .steps_done_o(steps_done)
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] wr(input logic [31:0] d);
        return {1'b1, CTRL, d};
    endfunction

    function automatic logic [64:0] rd();
        return {1'b0, IO, 32'h0};
    endfunction

    // Slave responder and bus monitor, all on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            ack = 1'b0; age = 0; linger_left = 0;
        end else begin
            dat_i = BASE + rd_idx;
            if (stb) begin
                age++;
                if (age > max_age) max_age = age;
                if (age == 1 && we && adr == CTRL && dat == 32'h85) lo_seen++;
                if (!(noack_hi && we && dat[3]) && age >= delay) ack = 1'b1;
                linger_left = linger;
                if (ack) begin
                    log_q.push_back({we, adr, dat});
                    if (age < delay) viol++;
                    if (!we) rd_idx++;
                end
            end else begin
                age = 0;
                if (ack) begin
                    if (linger_left > 0) linger_left--;
                    else ack = 1'b0;
                end
            end
            if (sample_vld) vld_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic clear_stats();
        log_q.delete(); exp_q.delete();
        rd_idx = 0; viol = 0; max_age = 0; vld_cnt = 0; done_cnt = 0; lo_seen = 0;
    endtask

    task automatic run_seq(input string tag, input logic [15:0] cnt);
        count = cnt; sel = 4'h8; hold_rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 2000 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 65'(done_cnt), 65'd1);
        check({tag, "_busy_end"}, 65'(busy), 65'd0);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_log_len"}, 65'(log_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < log_q.size()) check($sformatf("%s_bus%0d", tag, i), log_q[i], exp_q[i]);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 4'h0; hold_rst = 1'b0; count = 16'h0;
        ack = 1'b0; dat_i = 32'h0;
        #3;
        check("reset_outputs", {29'h0, cyc, stb, we, busy, done, err, sample_vld, adr},
              65'h0);
        check("reset_status", {21'h0, sample, steps_done}, 65'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Three steps with a 2-cycle ack
        clear_stats();
        exp_q.push_back(wr(32'h85));
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(wr(32'h8D)); exp_q.push_back(wr(32'h85)); exp_q.push_back(rd());
        end
        exp_q.push_back(wr(32'h0));
        run_seq("three", 16'd3);
        check_log("three");
        check("three_vld", 65'(vld_cnt), 65'd3);
        check("three_steps", 65'(steps_done), 65'd3);
        check("three_sample", 65'(sample), 65'h123_4562);
        check("three_err", 65'(err), 65'd0);

        // Zero steps: setup then release only
        clear_stats();
        exp_q.push_back(wr(32'h85)); exp_q.push_back(wr(32'h0));
        run_seq("zero", 16'd0);
        check_log("zero");
        check("zero_vld", 65'(vld_cnt), 65'd0);
        check("zero_steps", 65'(steps_done), 65'd0);

        // Ack lingers two cycles after strobe drops
        clear_stats();
        linger = 2;
        exp_q.push_back(wr(32'h85));
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back(wr(32'h8D)); exp_q.push_back(wr(32'h85)); exp_q.push_back(rd());
        end
        exp_q.push_back(wr(32'h0));
        run_seq("linger", 16'd2);
        check_log("linger");
        check("linger_overlap", 65'(viol), 65'd0);
        check("linger_vld", 65'(vld_cnt), 65'd2);
        linger = 0;

        // No ack on the clock-high write: timeout
        clear_stats();
        noack_hi = 1'b1;
        exp_q.push_back(wr(32'h85));
        run_seq("timeout", 16'd3);
        check_log("timeout");
        check("timeout_err", 65'(err), 65'd1);
        check("timeout_stb_len", 65'(max_age), 65'd16);
        check("timeout_vld", 65'(vld_cnt), 65'd0);
        noack_hi = 1'b0;
        clear_stats();
        run_seq("after_to", 16'd0);
        check("after_to_err", 65'(err), 65'd0);

        // Abort during the second clock-low write
        clear_stats();
        exp_q.push_back(wr(32'h85));
        exp_q.push_back(wr(32'h8D)); exp_q.push_back(wr(32'h85)); exp_q.push_back(rd());
        exp_q.push_back(wr(32'h8D)); exp_q.push_back(wr(32'h85));
        exp_q.push_back(wr(32'h0));
        fork
            run_seq("abort", 16'd3);
            begin
                for (int k = 0; k < 500 && lo_seen < 3; k++) begin
                    @(negedge clk); #1;
                end
                abort = 1'b1;
                @(negedge clk); #1;
                abort = 1'b0;
            end
        join
        check_log("abort");
        check("abort_steps", 65'(steps_done), 65'd1);
        check("abort_vld", 65'(vld_cnt), 65'd1);

        // Asynchronous reset in the middle of a bus cycle
        clear_stats();
        count = 16'd3; sel = 4'h8;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 50 && !stb; k++) @(negedge clk);
        check("rst_mid_cyc_seen", 65'(cyc), 65'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_drop", {62'h0, cyc, stb, busy}, 65'h0);
        @(negedge clk); rst_n = 1'b1;
        clear_stats();
        exp_q.push_back(wr(32'h85)); exp_q.push_back(wr(32'h0));
        run_seq("post_rst", 16'd0);
        check_log("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
